// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts write-through stores and streams 4-word
// refill blocks to the cache data array after a fixed busy latency.
// Ports: clk, rst (async high); mem_read/mem_write/addr/data_in request side;
//        ready (idle), miss_read/counter/read_data refill side, done pulse.
module main_mem_responder #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 1024,
   parameter int ADDRESS = 10,
   parameter int LATENCY = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [ADDRESS-1:0] addr,
   input  logic [WIDTH-1:0]   data_in,
   output logic               ready,
   output logic               miss_read,
   output logic [1:0]         counter,
   output logic [WIDTH-1:0]   read_data,
   output logic               done
);

   localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [WW-1:0] WAIT_INIT = WW'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_BURST,
      WR_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic               ready_q, ready_d;
   logic               miss_q, miss_d;
   logic               done_q, done_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]   rdata_q, rdata_d;
   logic [WW-1:0]      wait_q, wait_d;
   logic [ADDRESS-3:0] blk_q, blk_d;

   logic               mem_we;
   logic [1:0]         rd_word;
   logic [WIDTH-1:0]   mem_rd;
   logic [WIDTH-1:0]   mem [DEPTH];

   // Word fetched for the next refill beat: word 0 on leaving RD_WAIT,
   // otherwise the word after the one currently presented.
   always_comb begin
      rd_word = (state_q == RD_WAIT) ? 2'd0 : cnt_q + 2'd1;
      mem_rd  = mem[{blk_q, rd_word}];
   end

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      miss_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = 2'd0;
      rdata_d = rdata_q;
      wait_d  = wait_q;
      blk_d   = blk_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A read wins over a simultaneous store; the store is dropped.
            if (mem_read) begin
               state_d = RD_WAIT;
               ready_d = 1'b0;
               blk_d   = addr[ADDRESS-1:2];
               wait_d  = WAIT_INIT;
            end else if (mem_write) begin
               state_d = WR_WAIT;
               ready_d = 1'b0;
               wait_d  = WAIT_INIT;
               mem_we  = 1'b1;
               // With a one-cycle latency the accept cycle is also the last.
               done_d  = (LATENCY == 1);
            end
         end
         RD_WAIT: begin
            if (wait_q == '0) begin
               state_d = RD_BURST;
               miss_d  = 1'b1;
               cnt_d   = 2'd0;
               rdata_d = mem_rd;
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         RD_BURST: begin
            if (cnt_q == 2'd3) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               miss_d  = 1'b1;
               cnt_d   = cnt_q + 2'd1;
               rdata_d = mem_rd;
               done_d  = (cnt_q == 2'd2);
            end
         end
         WR_WAIT: begin
            if (wait_q == '0) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               wait_d = wait_q - 1'b1;
               done_d = (wait_q == WW'(1));
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ready_q <= 1'b1;
         miss_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= 2'd0;
         rdata_q <= '0;
         wait_q  <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         miss_q  <= miss_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         wait_q  <= wait_d;
         blk_q   <= blk_d;
      end
   end

   // Storage array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr] <= data_in;
      end
   end

   assign ready     = ready_q;
   assign miss_read = miss_q;
   assign counter   = cnt_q;
   assign read_data = rdata_q;
   assign done      = done_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Testbench for main_mem_responder: random stores/refills checked against
// a word-array memory model and cycle-offset timing rules.
module tb_main_mem_responder;

   localparam int L = 4;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [9:0]  addr;
   logic [31:0] data_in;
   logic        ready;
   logic        miss_read;
   logic [1:0]  counter;
   logic [31:0] read_data;
   logic        done;

   int n_cmp;
   int n_bad;

   logic [31:0] ref_mem [1024];

   logic        obs_ready [16];
   logic        obs_miss  [16];
   logic [1:0]  obs_cnt   [16];
   logic [31:0] obs_data  [16];
   logic        obs_done  [16];

   main_mem_responder #(
      .WIDTH(32), .DEPTH(1024), .ADDRESS(10), .LATENCY(L)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .data_in(data_in),
      .ready(ready), .miss_read(miss_read), .counter(counter),
      .read_data(read_data), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected behaviour k cycles after the accept edge (sampled after edge t0+k).
   function automatic logic rd_miss(int k);
      return (k >= L) && (k <= L + 3);
   endfunction
   function automatic logic [1:0] rd_cnt(int k);
      return rd_miss(k) ? 2'(k - L) : 2'd0;
   endfunction
   function automatic logic rd_done(int k);
      return k == L + 3;
   endfunction
   function automatic logic rd_ready(int k);
      return k >= L + 4;
   endfunction
   function automatic logic wr_ready(int k);
      return k >= L;
   endfunction
   function automatic logic wr_done(int k);
      return k == L - 1;
   endfunction
   function automatic logic [31:0] blk_word(logic [9:0] a, int w);
      logic [9:0] idx;
      idx = {a[9:2], 2'(w)};
      return ref_mem[idx];
   endfunction

   // Drives a request at the current negedge, holds it until accepted, then
   // records ncap negedge samples; waits = negedges spent waiting for ready.
   task automatic issue(input logic rd, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input int ncap, output int waits);
      mem_read  = rd;
      mem_write = wr;
      addr      = a;
      data_in   = d;
      waits     = 0;
      while (ready !== 1'b1 && waits < 64) begin
         @(negedge clk);
         waits++;
      end
      @(posedge clk);
      for (int k = 0; k < ncap; k++) begin
         @(negedge clk);
         if (k == 0) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
         obs_ready[k] = ready;
         obs_miss[k]  = miss_read;
         obs_cnt[k]   = counter;
         obs_data[k]  = read_data;
         obs_done[k]  = done;
      end
   endtask

   task automatic test_reset();
      #3 rst = 1'b1;
      #1;
      n_cmp += 5;
      if (ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_ready got %b want 1", ready);
      end
      if (miss_read !== 1'b0) begin
         n_bad++; $display("FAIL reset_miss got %b want 0", miss_read);
      end
      if (done !== 1'b0) begin
         n_bad++; $display("FAIL reset_done got %b want 0", done);
      end
      if (counter !== 2'd0) begin
         n_bad++; $display("FAIL reset_counter got %0d want 0", counter);
      end
      if (read_data !== 32'd0) begin
         n_bad++; $display("FAIL reset_data got %h want 0", read_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fill();
      int w;
      int late;
      late = 0;
      for (int i = 0; i < 1024; i++) begin
         ref_mem[i] = $urandom;
         issue(1'b0, 1'b1, 10'(i), ref_mem[i], L + 1, w);
         if (w != 0) late++;
      end
      n_cmp++;
      if (late != 0) begin
         n_bad++; $display("FAIL fill_accept got %0d late want 0", late);
      end
   endtask

   task automatic test_store();
      int w;
      ref_mem[5] = 32'hDEADBEEF;
      issue(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, L + 1, w);
      for (int k = 0; k <= L; k++) begin
         n_cmp += 2;
         if (obs_ready[k] !== wr_ready(k)) begin
            n_bad++;
            $display("FAIL store_ready k=%0d got %b want %b",
                     k, obs_ready[k], wr_ready(k));
         end
         if (obs_done[k] !== wr_done(k)) begin
            n_bad++;
            $display("FAIL store_done k=%0d got %b want %b",
                     k, obs_done[k], wr_done(k));
         end
      end
   endtask

   task automatic test_refill();
      int w;
      for (int i = 0; i < 4; i++) begin
         ref_mem[4 + i] = 32'hA0 + 32'(i);
         issue(1'b0, 1'b1, 10'(4 + i), 32'hA0 + 32'(i), L + 1, w);
      end
      issue(1'b1, 1'b0, 10'h006, 32'd0, L + 5, w);
      for (int k = 0; k < L + 5; k++) begin
         n_cmp += 4;
         if (obs_miss[k] !== rd_miss(k)) begin
            n_bad++;
            $display("FAIL refill_miss k=%0d got %b want %b",
                     k, obs_miss[k], rd_miss(k));
         end
         if (obs_cnt[k] !== rd_cnt(k)) begin
            n_bad++;
            $display("FAIL refill_cnt k=%0d got %0d want %0d",
                     k, obs_cnt[k], rd_cnt(k));
         end
         if (obs_done[k] !== rd_done(k)) begin
            n_bad++;
            $display("FAIL refill_done k=%0d got %b want %b",
                     k, obs_done[k], rd_done(k));
         end
         if (obs_ready[k] !== rd_ready(k)) begin
            n_bad++;
            $display("FAIL refill_ready k=%0d got %b want %b",
                     k, obs_ready[k], rd_ready(k));
         end
         if (rd_miss(k)) begin
            n_cmp++;
            if (obs_data[k] !== 32'hA0 + 32'(k - L)) begin
               n_bad++;
               $display("FAIL refill_data k=%0d got %h want %h",
                        k, obs_data[k], 32'hA0 + 32'(k - L));
            end
         end
      end
   endtask

   task automatic test_wrap();
      int w;
      issue(1'b1, 1'b0, 10'h3FF, 32'd0, L + 5, w);
      for (int k = L; k < L + 5; k++) begin
         n_cmp += 2;
         if (obs_cnt[k] !== rd_cnt(k)) begin
            n_bad++;
            $display("FAIL wrap_cnt k=%0d got %0d want %0d",
                     k, obs_cnt[k], rd_cnt(k));
         end
         if (obs_miss[k] !== rd_miss(k)) begin
            n_bad++;
            $display("FAIL wrap_miss k=%0d got %b want %b",
                     k, obs_miss[k], rd_miss(k));
         end
         if (rd_miss(k)) begin
            n_cmp++;
            if (obs_data[k] !== ref_mem[10'h3FC + 10'(k - L)]) begin
               n_bad++;
               $display("FAIL wrap_data k=%0d got %h want %h", k,
                        obs_data[k], ref_mem[10'h3FC + 10'(k - L)]);
            end
         end
      end
      issue(1'b1, 1'b0, 10'h010, 32'd0, L + 5, w);
      n_cmp += 2;
      if (w != 0) begin
         n_bad++; $display("FAIL wrap_next_accept got %0d waits want 0", w);
      end
      if (obs_data[L] !== blk_word(10'h010, 0)) begin
         n_bad++;
         $display("FAIL wrap_next_data got %h want %h",
                  obs_data[L], blk_word(10'h010, 0));
      end
   endtask

   task automatic test_back_to_back();
      int w;
      logic [31:0] d;
      d = $urandom;
      ref_mem[10'h0A1] = d;
      // Capture stops one cycle before ready rises, so the next request is
      // already held and must be taken at the very next edge.
      issue(1'b0, 1'b1, 10'h0A1, d, L, w);
      issue(1'b1, 1'b0, 10'h0A3, 32'd0, L + 4, w);
      n_cmp += 3;
      if (w != 1) begin
         n_bad++; $display("FAIL b2b_rd_accept got %0d waits want 1", w);
      end
      if (obs_miss[L] !== 1'b1) begin
         n_bad++; $display("FAIL b2b_rd_miss got %b want 1", obs_miss[L]);
      end
      if (obs_data[L + 1] !== d) begin
         n_bad++;
         $display("FAIL b2b_rd_data got %h want %h", obs_data[L + 1], d);
      end
      d = $urandom;
      ref_mem[10'h0B0] = d;
      issue(1'b0, 1'b1, 10'h0B0, d, L + 1, w);
      n_cmp += 2;
      if (w != 1) begin
         n_bad++; $display("FAIL b2b_wr_accept got %0d waits want 1", w);
      end
      if (obs_done[L - 1] !== 1'b1) begin
         n_bad++; $display("FAIL b2b_wr_done got %b want 1", obs_done[L - 1]);
      end
      issue(1'b1, 1'b0, 10'h0B0, 32'd0, L + 5, w);
      n_cmp += 2;
      if (w != 0) begin
         n_bad++; $display("FAIL b2b_after_wr got %0d waits want 0", w);
      end
      if (obs_data[L] !== d) begin
         n_bad++; $display("FAIL b2b_wr_read got %h want %h", obs_data[L], d);
      end
   endtask

   task automatic test_contention();
      int w;
      int busy_hi;
      logic [31:0] junk;
      junk = ~ref_mem[10'h122];
      issue(1'b1, 1'b1, 10'h122, junk, L + 5, w);
      n_cmp += 2;
      if (obs_miss[L] !== 1'b1) begin
         n_bad++; $display("FAIL cont_burst got %b want 1", obs_miss[L]);
      end
      if (obs_data[L + 2] !== ref_mem[10'h122]) begin
         n_bad++;
         $display("FAIL cont_old_data got %h want %h",
                  obs_data[L + 2], ref_mem[10'h122]);
      end
      issue(1'b1, 1'b0, 10'h200, 32'd0, 2, w);
      mem_write = 1'b1;
      addr      = 10'h201;
      data_in   = ~ref_mem[10'h201];
      busy_hi   = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (ready !== 1'b0) busy_hi++;
      end
      mem_write = 1'b0;
      n_cmp++;
      if (busy_hi != 0) begin
         n_bad++; $display("FAIL busy_ready got %0d high want 0", busy_hi);
      end
      issue(1'b1, 1'b0, 10'h201, 32'd0, L + 5, w);
      n_cmp += 2;
      if (w > 16) begin
         n_bad++; $display("FAIL busy_drain got %0d waits want <=16", w);
      end
      if (obs_data[L + 1] !== ref_mem[10'h201]) begin
         n_bad++;
         $display("FAIL busy_ignored got %h want %h",
                  obs_data[L + 1], ref_mem[10'h201]);
      end
   endtask

   task automatic test_abort();
      int w;
      int stray;
      issue(1'b1, 1'b0, 10'h155, 32'd0, L + 2, w);
      n_cmp++;
      if (obs_cnt[L + 1] !== 2'd1) begin
         n_bad++; $display("FAIL abort_pre_cnt got %0d want 1", obs_cnt[L + 1]);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp += 3;
      if (miss_read !== 1'b0) begin
         n_bad++; $display("FAIL abort_miss got %b want 0", miss_read);
      end
      if (ready !== 1'b1) begin
         n_bad++; $display("FAIL abort_ready got %b want 1", ready);
      end
      if (counter !== 2'd0) begin
         n_bad++; $display("FAIL abort_cnt got %0d want 0", counter);
      end
      @(negedge clk);
      rst   = 1'b0;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (miss_read !== 1'b0) stray++;
      end
      n_cmp++;
      if (stray != 0) begin
         n_bad++; $display("FAIL abort_stray got %0d want 0", stray);
      end
      issue(1'b1, 1'b0, 10'h155, 32'd0, L + 5, w);
      for (int k = L; k < L + 4; k++) begin
         n_cmp++;
         if (obs_data[k] !== blk_word(10'h155, k - L)) begin
            n_bad++;
            $display("FAIL abort_refill k=%0d got %h want %h",
                     k, obs_data[k], blk_word(10'h155, k - L));
         end
      end
   endtask

   task automatic test_random();
      int w;
      logic [9:0] a;
      logic [31:0] d;
      for (int it = 0; it < 60; it++) begin
         a = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            ref_mem[a] = d;
            issue(1'b0, 1'b1, a, d, L + 1, w);
            n_cmp += 2;
            if (w != 0) begin
               n_bad++; $display("FAIL rnd_wr_accept got %0d want 0", w);
            end
            if (obs_ready[L - 1] !== 1'b0 || obs_ready[L] !== 1'b1) begin
               n_bad++;
               $display("FAIL rnd_wr_ready got %b%b want 01",
                        obs_ready[L - 1], obs_ready[L]);
            end
         end else begin
            issue(1'b1, 1'b0, a, 32'd0, L + 5, w);
            for (int k = 0; k < L + 5; k++) begin
               n_cmp += 2;
               if (obs_miss[k] !== rd_miss(k)) begin
                  n_bad++;
                  $display("FAIL rnd_miss it=%0d k=%0d got %b want %b",
                           it, k, obs_miss[k], rd_miss(k));
               end
               if (obs_cnt[k] !== rd_cnt(k)) begin
                  n_bad++;
                  $display("FAIL rnd_cnt it=%0d k=%0d got %0d want %0d",
                           it, k, obs_cnt[k], rd_cnt(k));
               end
               if (rd_miss(k)) begin
                  n_cmp++;
                  if (obs_data[k] !== blk_word(a, k - L)) begin
                     n_bad++;
                     $display("FAIL rnd_data a=%h k=%0d got %h want %h",
                              a, k, obs_data[k], blk_word(a, k - L));
                  end
               end
            end
         end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr      = '0;
      data_in   = '0;
      test_reset();
      test_fill();
      test_store();
      test_refill();
      test_wrap();
      test_back_to_back();
      test_contention();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
